// File: rtl/alu_pkg.sv
// alu_pkg: encodings shared by the ALU and the ALU arbiter.
//   OP_ADD/OP_SUB/OP_AND/OP_OR : ALU select codes (S input)
//   state_t                    : sequencing FSM states of alu_arbiter
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/ALU.sv
// ALU: 4-bit combinational ALU.
// Ports:
//   A, B : operands (4 bits)
//   S    : select, 00 add, 01 sub, 10 AND, 11 OR
//   C    : result (4 bits, wrap-around)
//   Co   : carry out for add/sub (1 = no borrow on sub), 0 for AND/OR
module ALU
  import alu_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] S,
  output logic [3:0] C,
  output logic       Co
);

  logic [4:0] sum;

  // Result and carry selection for the four operations.
  always_comb begin
    sum = 5'd0;
    C   = 4'd0;
    Co  = 1'b0;
    case (S)
      OP_ADD: begin
        sum = {1'b0, A} + {1'b0, B};
        C   = sum[3:0];
        Co  = sum[4];
      end
      OP_SUB: begin
        // Two's-complement subtract: carry set means no borrow.
        sum = {1'b0, A} + {1'b0, ~B} + 5'd1;
        C   = sum[3:0];
        Co  = sum[4];
      end
      OP_AND: begin
        C  = A & B;
        Co = 1'b0;
      end
      OP_OR: begin
        C  = A | B;
        Co = 1'b0;
      end
      default: begin
        C  = 4'd0;
        Co = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational grant selection between two requesters.
// Parameters:
//   PRIO_FIXED : 0 = round-robin on ties, 1 = requester 0 wins ties
// Ports:
//   valid0, valid1 : request pending from requester 0 / 1
//   last_gnt       : index of the requester granted most recently
//   grant0, grant1 : one-hot (or zero) grant
module alu_arb_pick #(
  parameter int PRIO_FIXED = 0
) (
  input  logic valid0,
  input  logic valid1,
  input  logic last_gnt,
  output logic grant0,
  output logic grant1
);

  // Tie resolution: fixed priority or favour the requester not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      if (PRIO_FIXED != 0) begin
        grant0 = 1'b1;
      end else if (last_gnt) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (valid0) begin
      grant0 = 1'b1;
    end else if (valid1) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters and returns
// each result on a single tagged valid/ready response channel.
// Parameters:
//   PRIO_FIXED : 0 = round-robin, 1 = requester 0 wins ties
// Optional feature: define ALU_ARB_STATS_EN to add saturating 8-bit grant
// counters gnt0_cnt / gnt1_cnt.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b     : request channel of requester N (N = 0, 1)
//   rsp_valid/ready/id/c/co     : response channel (id = owning requester)
//   busy                        : FSM not in IDLE
//   gnt0_cnt, gnt1_cnt          : acceptance counters (ALU_ARB_STATS_EN only)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_c,
  output logic       rsp_co,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0] gnt0_cnt,
  output logic [7:0] gnt1_cnt,
`endif
  output logic       busy
);

  state_t     state;
  state_t     state_next;
  logic       last_gnt;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic [1:0] op_lat;
  logic [3:0] a_lat;
  logic [3:0] b_lat;
  logic       id_lat;
  logic [3:0] alu_c;
  logic       alu_co;

  alu_arb_pick #(
    .PRIO_FIXED(PRIO_FIXED)
  ) u_pick (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .last_gnt (last_gnt),
    .grant0   (grant0),
    .grant1   (grant1)
  );

  ALU u_alu (
    .A  (a_lat),
    .B  (b_lat),
    .S  (op_lat),
    .C  (alu_c),
    .Co (alu_co)
  );

  // Ready is only offered in IDLE; the picker guarantees at most one grant.
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, grant history and registered response/busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_lat    <= 2'b00;
      a_lat     <= 4'd0;
      b_lat     <= 4'd0;
      id_lat    <= 1'b0;
      last_gnt  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_c     <= 4'd0;
      rsp_co    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (accept) begin
        op_lat   <= req1_ready ? req1_op : req0_op;
        a_lat    <= req1_ready ? req1_a  : req0_a;
        b_lat    <= req1_ready ? req1_b  : req0_b;
        id_lat   <= req1_ready;
        last_gnt <= req1_ready;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_lat;
        rsp_c     <= alu_c;
        rsp_co    <= alu_co;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_cnt <= 8'd0;
      gnt1_cnt <= 8'd0;
    end else begin
      if (req0_ready && (gnt0_cnt != 8'hFF)) begin
        gnt0_cnt <= gnt0_cnt + 8'd1;
      end
      if (req1_ready && (gnt1_cnt != 8'hFF)) begin
        gnt1_cnt <= gnt1_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter. A second
// instance built with PRIO_FIXED=1 shares the request inputs and rsp_ready.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [1:0] req0_op = 2'b00;
  logic [3:0] req0_a = 4'd0;
  logic [3:0] req0_b = 4'd0;
  logic       req1_valid = 1'b0;
  logic [1:0] req1_op = 2'b00;
  logic [3:0] req1_a = 4'd0;
  logic [3:0] req1_b = 4'd0;
  logic       rsp_ready = 1'b1;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_co, busy;
  logic [3:0] rsp_c;
  logic       f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_co, f_busy;
  logic [3:0] f_rsp_c;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt0_cnt, gnt1_cnt, f_gnt0_cnt, f_gnt1_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int rule_viol = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_co(rsp_co),
`ifdef ALU_ARB_STATS_EN
    .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt),
`endif
    .busy(busy)
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fix (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
    .rsp_c(f_rsp_c), .rsp_co(f_rsp_co),
`ifdef ALU_ARB_STATS_EN
    .gnt0_cnt(f_gnt0_cnt), .gnt1_cnt(f_gnt1_cnt),
`endif
    .busy(f_busy)
  );

  // Requester rule monitor: a pending, unaccepted request must stay valid and stable.
  logic       pv0, pr0, pv1, pr1;
  logic [9:0] pp0, pp1;
  always @(posedge clk) begin
    if (rst) begin
      pv0 <= 1'b0; pr0 <= 1'b0; pv1 <= 1'b0; pr1 <= 1'b0;
      pp0 <= 10'd0; pp1 <= 10'd0;
    end else begin
      if (pv0 && !pr0 && (!req0_valid || (pp0 != {req0_op, req0_a, req0_b})))
        rule_viol <= rule_viol + 1;
      if (pv1 && !pr1 && (!req1_valid || (pp1 != {req1_op, req1_a, req1_b})))
        rule_viol <= rule_viol + 1;
      pv0 <= req0_valid; pr0 <= req0_ready; pp0 <= {req0_op, req0_a, req0_b};
      pv1 <= req1_valid; pr1 <= req1_ready; pp1 <= {req1_op, req1_a, req1_b};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait for the main instance to accept requester id; returns 1 if accepted.
  task automatic wait_accept(input logic id, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
  endtask

  // Issue one request (rsp_ready held high) and check the full response.
  task automatic do_req(input string tag, input logic id, input logic [1:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ec, input logic eco);
    logic ok;
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    wait_accept(id, ok);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq({tag, "_acc"}, 32'(ok), 32'd1);
    check_eq({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_exec_busy"}, 32'(busy), 32'd1);
    tick();
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
    check_eq({tag, "_c"}, 32'(rsp_c), 32'(ec));
    check_eq({tag, "_co"}, 32'(rsp_co), 32'(eco));
    tick();
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic       ok;
    logic [3:0] seq_rr;
    logic [3:0] seq_fx;
    int         n_rr;
    int         n_fx;

    // Reset values
    #2;
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_c", 32'({rsp_id, rsp_c, rsp_co}), 32'd0);
    do_reset();
    check_eq("rel_valid", 32'(rsp_valid), 32'd0);
    check_eq("rel_busy", 32'(busy), 32'd0);
    check_eq("rel_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // Arithmetic and logic vectors
    do_req("add75", 1'b0, OP_ADD, 4'h7, 4'h5, 4'hC, 1'b0);
    do_req("addwrap", 1'b1, OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1);
    do_req("sub35", 1'b1, OP_SUB, 4'h3, 4'h5, 4'hE, 1'b0);
    do_req("sub53", 1'b0, OP_SUB, 4'h5, 4'h3, 4'h2, 1'b1);
    do_req("and", 1'b0, OP_AND, 4'hC, 4'hA, 4'h8, 1'b0);
    do_req("or", 1'b0, OP_OR, 4'hC, 4'hA, 4'hE, 1'b0);

    // Arbitration: both requesters valid continuously
    do_reset();
    req0_op = OP_ADD; req0_a = 4'h1; req0_b = 4'h1; req0_valid = 1'b1;
    req1_op = OP_ADD; req1_a = 4'h2; req1_b = 4'h2; req1_valid = 1'b1;
    seq_rr = 4'hF; seq_fx = 4'hF; n_rr = 0; n_fx = 0;
    for (int i = 0; i < 40 && (n_rr < 4 || n_fx < 4); i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && n_rr < 4) begin
        seq_rr[n_rr] = rsp_id;
        n_rr++;
      end
      if (f_rsp_valid && rsp_ready && n_fx < 4) begin
        seq_fx[n_fx] = f_rsp_id;
        n_fx++;
      end
    end
    check_eq("rr_count", 32'(n_rr), 32'd4);
    check_eq("rr_seq", 32'(seq_rr), 32'h0000_000A);
    check_eq("fix_count", 32'(n_fx), 32'd4);
    check_eq("fix_seq", 32'(seq_fx), 32'd0);
    do_reset();

    // Back-pressure with a request waiting behind the held response
    rsp_ready = 1'b0;
    req0_op = OP_ADD; req0_a = 4'h2; req0_b = 4'h3; req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    req0_valid = 1'b0;
    check_eq("bp_acc", 32'(ok), 32'd1);
    tick();
    req1_op = OP_ADD; req1_a = 4'h1; req1_b = 4'h2; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold", 32'({rsp_valid, rsp_id, rsp_c, rsp_co}), 32'({1'b1, 1'b0, 4'h5, 1'b0}));
      check_eq("bp_busy", 32'(busy), 32'd1);
      check_eq("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_idle", 32'(busy), 32'd0);
    check_eq("bp_grant1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check_eq("bp_exec", 32'(busy), 32'd1);
    tick();
    check_eq("bp_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_co}), 32'({1'b1, 1'b1, 4'h3, 1'b0}));
    tick();

    // Reset asserted while the operation is in EXEC
    req0_op = OP_ADD; req0_a = 4'h7; req0_b = 4'h5; req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    req0_valid = 1'b0;
    check_eq("mr_acc", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mr_async", 32'({rsp_valid, busy, rsp_id, rsp_c, rsp_co}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("mr_noresp", 32'({rsp_valid, busy}), 32'd0);
    do_req("mr_after", 1'b0, OP_SUB, 4'h0, 4'h1, 4'hF, 1'b0);

`ifdef ALU_ARB_STATS_EN
    // Saturating grant counter
    do_reset();
    req0_op = OP_OR; req0_a = 4'h1; req0_b = 4'h2; req0_valid = 1'b1;
    n_rr = 0;
    for (int i = 0; i < 2000 && n_rr < 300; i++) begin
      @(negedge clk);
      if (req0_ready) n_rr++;
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    check_eq("st_grants", 32'(n_rr), 32'd300);
    check_eq("st_cnt0", 32'(gnt0_cnt), 32'd255);
    check_eq("st_cnt1", 32'(gnt1_cnt), 32'd0);
    check_eq("st_fix_cnt0", 32'(f_gnt0_cnt), 32'd255);
`endif

    tick();
    check_eq("req_rule", 32'(rule_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
